// File: rtl/tap_seq_pkg.sv
// Shared types and limits for the JTAG TAP sequencer: opcodes, tracked TAP
// states, shift length bound and reset-walk length.
package tap_seq_pkg;

   localparam int MAX_LEN    = 32;
   localparam int RESET_WALK = 5;

   typedef enum logic [1:0] {
      OP_RESET    = 2'b00,
      OP_IDLE     = 2'b01,
      OP_SHIFT_IR = 2'b10,
      OP_SHIFT_DR = 2'b11
   } tap_op_e;

   typedef enum logic [2:0] {
      ST_WALK_RST,
      ST_IDLE,
      ST_SEL_DR,
      ST_SEL_IR,
      ST_CAPTURE,
      ST_SHIFT,
      ST_EXIT1,
      ST_UPDATE
   } tap_state_e;

   // Effective length minus one: 0 behaves as 1, anything above MAX_LEN saturates.
   function automatic logic [4:0] eff_len_m1(input logic [5:0] len);
      logic [4:0] r;
      if (len == 6'd0)
         r = 5'd0;
      else if (len > 6'(MAX_LEN))
         r = 5'(MAX_LEN - 1);
      else
         r = 5'(len - 6'd1);
      return r;
   endfunction

endpackage

// File: rtl/tap_seq_shifter.sv
// TDI shift register, shift bit counter and (with TAP_SEQ_TDO_CAPTURE_EN)
// the TDO capture / response registers. TDI side moves on falling TCLK.
module tap_seq_shifter
   import tap_seq_pkg::*;
(
   input  logic                TCLK,
   input  logic                rst,
   input  logic                load,
   input  logic [MAX_LEN-1:0]  load_data,
   input  logic                in_shift,
   input  logic                tdo,
   input  logic                rsp_latch,
   output logic                tdi,
   output logic [4:0]          bit_cnt,
   output logic [MAX_LEN-1:0]  rsp_data
);

   logic [MAX_LEN-1:0] sr;

   // bit_cnt equals the index of the shift cycle in progress
   always_ff @(negedge TCLK) begin
      if (rst) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         sr      <= load_data;
         bit_cnt <= '0;
      end else if (in_shift) begin
         sr      <= sr >> 1;
         bit_cnt <= bit_cnt + 5'd1;
      end
   end

   assign tdi = in_shift & sr[0];

`ifdef TAP_SEQ_TDO_CAPTURE_EN
   logic [MAX_LEN-1:0] cap;

   // First bit of a shift clears the rest so bits above the length read 0.
   always_ff @(posedge TCLK) begin
      if (in_shift) begin
         if (bit_cnt == 5'd0)
            cap <= {{(MAX_LEN-1){1'b0}}, tdo};
         else
            cap[bit_cnt] <= tdo;
      end
   end

   always_ff @(negedge TCLK) begin
      if (rst)
         rsp_data <= '0;
      else if (rsp_latch)
         rsp_data <= cap;
   end
`else
   logic unused_capture;
   assign unused_capture = tdo ^ rsp_latch;
   assign rsp_data       = '0;
`endif

endmodule

// File: rtl/tap_sequencer.sv
// JTAG TAP sequencer: runs RESET/IDLE/SHIFT_IR/SHIFT_DR commands on TMS/TDI.
// TDO capture is built only with TAP_SEQ_TDO_CAPTURE_EN defined.
//
// state    | meaning
// WALK_RST | TMS=1 walk into Test-Logic-Reset, then one TMS=0 cycle
// IDLE     | Run-Test/Idle; ready, or running an IDLE op / first cycle of a shift
// SEL_DR   | Select-DR-Scan (TMS=1 again for IR ops)
// SEL_IR   | Select-IR-Scan
// CAPTURE  | Capture-DR/IR
// SHIFT    | Shift-DR/IR, one bit per cycle, TMS=1 on the last bit
// EXIT1    | Exit1, TMS=1 into Update
// UPDATE   | Update, TMS=0 back to Run-Test/Idle
module tap_sequencer
   import tap_seq_pkg::*;
(
   input  logic        TCLK,
   input  logic        Rst,
   input  logic        CmdValid,
   output logic        CmdReady,
   input  logic [1:0]  CmdOp,
   input  logic [5:0]  CmdLen,
   input  logic [31:0] CmdData,
   input  logic        TDO,
   output logic        TMS,
   output logic        TDI,
   output logic        RspValid,
   output logic [31:0] RspData,
   output logic        Busy
);

   tap_state_e state;
   tap_op_e    op;
   logic [4:0] len_m1;
   logic [5:0] cnt;
   logic       tms;
   logic       cmd_ready;
   logic       rsp_valid;
   logic [4:0] bit_cnt;
   logic       accept;
   logic       in_shift;
   logic       rsp_latch;

   assign accept    = cmd_ready & CmdValid & (state == ST_IDLE);
   assign in_shift  = (state == ST_SHIFT);
   assign rsp_latch = (state == ST_UPDATE);

   // Each falling edge picks the state and TMS value for the cycle it opens.
   always_ff @(negedge TCLK) begin
      if (Rst) begin
         state     <= ST_WALK_RST;
         op        <= OP_RESET;
         len_m1    <= '0;
         cnt       <= 6'(RESET_WALK + 1);
         tms       <= 1'b1;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_WALK_RST: begin
               if (cnt == 6'd0) begin
                  state     <= ST_IDLE;
                  tms       <= 1'b0;
                  cmd_ready <= 1'b1;
               end else begin
                  tms <= (cnt > 6'd1);
                  cnt <= cnt - 6'd1;
               end
            end
            ST_IDLE: begin
               if (cmd_ready) begin
                  tms <= 1'b0;
                  if (accept) begin
                     op        <= tap_op_e'(CmdOp);
                     len_m1    <= eff_len_m1(CmdLen);
                     cmd_ready <= 1'b0;
                     case (tap_op_e'(CmdOp))
                        OP_RESET: begin
                           state <= ST_WALK_RST;
                           tms   <= 1'b1;
                           cnt   <= 6'(RESET_WALK);
                        end
                        OP_IDLE:  cnt <= {1'b0, eff_len_m1(CmdLen)};
                        default:  tms <= 1'b1;
                     endcase
                  end
               end else begin
                  case (op)
                     OP_IDLE: begin
                        tms <= 1'b0;
                        if (cnt == 6'd0)
                           cmd_ready <= 1'b1;
                        else
                           cnt <= cnt - 6'd1;
                     end
                     OP_SHIFT_IR, OP_SHIFT_DR: begin
                        state <= ST_SEL_DR;
                        tms   <= (op == OP_SHIFT_IR);
                     end
                     default: begin
                        tms       <= 1'b0;
                        cmd_ready <= 1'b1;
                     end
                  endcase
               end
            end
            ST_SEL_DR: begin
               state <= (op == OP_SHIFT_IR) ? ST_SEL_IR : ST_CAPTURE;
               tms   <= 1'b0;
            end
            ST_SEL_IR: begin
               state <= ST_CAPTURE;
               tms   <= 1'b0;
            end
            ST_CAPTURE: begin
               state <= ST_SHIFT;
               tms   <= (len_m1 == 5'd0);
            end
            ST_SHIFT: begin
               if (bit_cnt == len_m1) begin
                  state <= ST_EXIT1;
                  tms   <= 1'b1;
               end else begin
                  tms <= (5'(bit_cnt + 5'd1) == len_m1);
               end
            end
            ST_EXIT1: begin
               state <= ST_UPDATE;
               tms   <= 1'b0;
            end
            ST_UPDATE: begin
               state     <= ST_IDLE;
               tms       <= 1'b0;
               cmd_ready <= 1'b1;
               rsp_valid <= 1'b1;
            end
            default: begin
               state <= ST_WALK_RST;
               tms   <= 1'b1;
               cnt   <= 6'(RESET_WALK + 1);
            end
         endcase
      end
   end

   tap_seq_shifter u_shifter (
      .TCLK      (TCLK),
      .rst       (Rst),
      .load      (accept),
      .load_data (CmdData),
      .in_shift  (in_shift),
      .tdo       (TDO),
      .rsp_latch (rsp_latch),
      .tdi       (TDI),
      .bit_cnt   (bit_cnt),
      .rsp_data  (RspData)
   );

   assign TMS      = tms;
   assign CmdReady = cmd_ready;
   assign RspValid = rsp_valid;
   assign Busy     = ~cmd_ready;

endmodule

// File: tb/tb_tap_sequencer.sv
// Directed self-checking bench for tap_sequencer.
module tb_tap_sequencer;

   logic        TCLK = 1'b1;
   logic        Rst = 1'b1;
   logic        CmdValid = 1'b0;
   logic [1:0]  CmdOp = 2'b00;
   logic [5:0]  CmdLen = 6'd0;
   logic [31:0] CmdData = 32'd0;
   logic        TDO;
   logic        CmdReady, TMS, TDI, RspValid, Busy;
   logic [31:0] RspData;

   logic tdo_loop = 1'b0;
   logic tdo_val  = 1'b0;
   assign TDO = tdo_loop ? TDI : tdo_val;

`ifdef TAP_SEQ_TDO_CAPTURE_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   logic [127:0] tms_log, tdi_log;
   int           ncyc;
   logic         rv_during, rv_end;

   tap_sequencer dut (
      .TCLK     (TCLK),
      .Rst      (Rst),
      .CmdValid (CmdValid),
      .CmdReady (CmdReady),
      .CmdOp    (CmdOp),
      .CmdLen   (CmdLen),
      .CmdData  (CmdData),
      .TDO      (TDO),
      .TMS      (TMS),
      .TDI      (TDI),
      .RspValid (RspValid),
      .RspData  (RspData),
      .Busy     (Busy)
   );

   always #5 TCLK = ~TCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(negedge TCLK);
      #1;
   endtask

   // Issue one command from a ready cycle, log TMS/TDI until ready returns.
   task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
      CmdOp = op; CmdLen = len; CmdData = data; CmdValid = 1'b1;
      cyc();
      CmdValid = 1'b0;
      ncyc = 0; tms_log = '0; tdi_log = '0; rv_during = 1'b0;
      while (CmdReady !== 1'b1 && ncyc < 100) begin
         tms_log[ncyc] = TMS;
         tdi_log[ncyc] = TDI;
         rv_during = rv_during | (RspValid === 1'b1);
         ncyc++;
         cyc();
      end
      rv_end = RspValid;
   endtask

   task automatic test_reset();
      logic [5:0] walk;
      logic       rdy_any;
      Rst = 1'b1;
      repeat (3) cyc();
      checks++; if (TMS !== 1'b1) begin errors++; $display("FAIL rst_tms: got %b want 1", TMS); end
      checks++; if (TDI !== 1'b0) begin errors++; $display("FAIL rst_tdi: got %b want 0", TDI); end
      checks++; if (CmdReady !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", CmdReady); end
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", Busy); end
      checks++; if (RspValid !== 1'b0) begin errors++; $display("FAIL rst_rspvalid: got %b want 0", RspValid); end
      checks++; if (RspData !== 32'd0) begin errors++; $display("FAIL rst_rspdata: got %h want 0", RspData); end
      Rst = 1'b0;
      rdy_any = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         walk[i] = TMS;
         rdy_any = rdy_any | (CmdReady === 1'b1);
      end
      checks++; if (walk !== 6'b011111) begin errors++; $display("FAIL rst_walk_tms: got %b want 011111", walk); end
      checks++; if (rdy_any !== 1'b0) begin errors++; $display("FAIL rst_walk_ready: got %b want 0", rdy_any); end
      cyc();
      checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL rst_ready_c7: got %b want 1", CmdReady); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy_c7: got %b want 0", Busy); end
      checks++; if (TMS !== 1'b0) begin errors++; $display("FAIL rst_idle_tms: got %b want 0", TMS); end
   endtask

   task automatic test_reset_op();
      run_cmd(2'b00, 6'd7, 32'd0);
      checks++; if (ncyc !== 6) begin errors++; $display("FAIL resetop_cycles: got %0d want 6", ncyc); end
      checks++; if (tms_log[5:0] !== 6'b011111) begin errors++; $display("FAIL resetop_tms: got %b want 011111", tms_log[5:0]); end
      checks++; if ((rv_end | rv_during) !== 1'b0) begin errors++; $display("FAIL resetop_rspvalid: got %b want 0", rv_end | rv_during); end
   endtask

   task automatic test_idle();
      run_cmd(2'b01, 6'd0, 32'd0);
      checks++; if (ncyc !== 1) begin errors++; $display("FAIL idle0_cycles: got %0d want 1", ncyc); end
      checks++; if (tms_log[0] !== 1'b0) begin errors++; $display("FAIL idle0_tms: got %b want 0", tms_log[0]); end
      checks++; if (rv_end !== 1'b0) begin errors++; $display("FAIL idle0_rspvalid: got %b want 0", rv_end); end
      run_cmd(2'b01, 6'd3, 32'd0);
      checks++; if (ncyc !== 3) begin errors++; $display("FAIL idle3_cycles: got %0d want 3", ncyc); end
      checks++; if (tms_log[2:0] !== 3'b000) begin errors++; $display("FAIL idle3_tms: got %b want 000", tms_log[2:0]); end
      run_cmd(2'b01, 6'd63, 32'd0);
      checks++; if (ncyc !== 32) begin errors++; $display("FAIL idle63_cycles: got %0d want 32", ncyc); end
      checks++; if (TMS !== 1'b0) begin errors++; $display("FAIL idle_wait_tms: got %b want 0", TMS); end
   endtask

   task automatic test_shift_ir();
      logic [31:0] exp_rsp;
      exp_rsp = CAP_EN ? 32'h0000_000F : 32'h0;
      tdo_loop = 1'b0; tdo_val = 1'b1;
      run_cmd(2'b10, 6'd4, 32'h0000_0005);
      checks++; if (ncyc !== 10) begin errors++; $display("FAIL ir_cycles: got %0d want 10", ncyc); end
      checks++; if (tms_log[9:0] !== 10'h183) begin errors++; $display("FAIL ir_tms: got %b want 0110000011", tms_log[9:0]); end
      checks++; if (tdi_log[9:0] !== 10'h050) begin errors++; $display("FAIL ir_tdi: got %b want 0001010000", tdi_log[9:0]); end
      checks++; if (rv_during !== 1'b0) begin errors++; $display("FAIL ir_early_rspvalid: got %b want 0", rv_during); end
      checks++; if (rv_end !== 1'b1) begin errors++; $display("FAIL ir_rspvalid: got %b want 1", rv_end); end
      checks++; if (RspData !== exp_rsp) begin errors++; $display("FAIL ir_rspdata: got %h want %h", RspData, exp_rsp); end
      cyc();
      checks++; if (RspValid !== 1'b0) begin errors++; $display("FAIL ir_pulse_width: got %b want 0", RspValid); end
      checks++; if (RspData !== exp_rsp) begin errors++; $display("FAIL ir_rsp_hold: got %h want %h", RspData, exp_rsp); end
   endtask

   task automatic test_shift_len1();
      logic [31:0] exp_rsp;
      exp_rsp = CAP_EN ? 32'h0000_0001 : 32'h0;
      tdo_loop = 1'b0; tdo_val = 1'b1;
      run_cmd(2'b11, 6'd1, 32'hFFFF_FFFF);
      checks++; if (ncyc !== 6) begin errors++; $display("FAIL dr1_cycles: got %0d want 6", ncyc); end
      checks++; if (tms_log[5:0] !== 6'b011001) begin errors++; $display("FAIL dr1_tms: got %b want 011001", tms_log[5:0]); end
      checks++; if (tdi_log[5:0] !== 6'b001000) begin errors++; $display("FAIL dr1_tdi: got %b want 001000", tdi_log[5:0]); end
      checks++; if (RspData !== exp_rsp) begin errors++; $display("FAIL dr1_rspdata: got %h want %h", RspData, exp_rsp); end
   endtask

   task automatic test_shift_dr_clamp();
      logic [31:0] exp_rsp;
      exp_rsp = CAP_EN ? 32'hA5A5_A5A5 : 32'h0;
      tdo_loop = 1'b1;
      run_cmd(2'b11, 6'd40, 32'hA5A5_A5A5);
      checks++; if (ncyc !== 37) begin errors++; $display("FAIL dr40_cycles: got %0d want 37", ncyc); end
      checks++; if (tms_log[36:0] !== 37'h0C_0000_0001) begin errors++; $display("FAIL dr40_tms: got %h want 0c00000001", tms_log[36:0]); end
      checks++; if (tdi_log[34:3] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL dr40_tdi: got %h want a5a5a5a5", tdi_log[34:3]); end
      checks++; if ({tdi_log[36:35], tdi_log[2:0]} !== 5'b0) begin errors++; $display("FAIL dr40_tdi_idle: got %b want 00000", {tdi_log[36:35], tdi_log[2:0]}); end
      checks++; if (rv_end !== 1'b1) begin errors++; $display("FAIL dr40_rspvalid: got %b want 1", rv_end); end
      checks++; if (RspData !== exp_rsp) begin errors++; $display("FAIL dr40_rspdata: got %h want %h", RspData, exp_rsp); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] held;
      held = CAP_EN ? 32'hA5A5_A5A5 : 32'h0;
      run_cmd(2'b01, 6'd2, 32'd0);
      checks++; if (ncyc !== 2) begin errors++; $display("FAIL b2b_idle_cycles: got %0d want 2", ncyc); end
      checks++; if (rv_end !== 1'b0) begin errors++; $display("FAIL b2b_idle_rspvalid: got %b want 0", rv_end); end
      checks++; if (RspData !== held) begin errors++; $display("FAIL b2b_rsp_hold: got %h want %h", RspData, held); end
      tdo_loop = 1'b1;
      run_cmd(2'b10, 6'd8, 32'h0000_003C);
      checks++; if (ncyc !== 14) begin errors++; $display("FAIL b2b_ir8_cycles: got %0d want 14", ncyc); end
      checks++; if (rv_end !== 1'b1) begin errors++; $display("FAIL b2b_ir8_rspvalid: got %b want 1", rv_end); end
      checks++; if (RspData !== (CAP_EN ? 32'h3C : 32'h0)) begin errors++; $display("FAIL b2b_ir8_rspdata: got %h want %h", RspData, CAP_EN ? 32'h3C : 32'h0); end
      run_cmd(2'b11, 6'd3, 32'h0000_0005);
      checks++; if (ncyc !== 8) begin errors++; $display("FAIL b2b_dr3_cycles: got %0d want 8", ncyc); end
      checks++; if (tdi_log[7:0] !== 8'b0010_1000) begin errors++; $display("FAIL b2b_dr3_tdi: got %b want 00101000", tdi_log[7:0]); end
      checks++; if (RspData !== (CAP_EN ? 32'h5 : 32'h0)) begin errors++; $display("FAIL b2b_dr3_rspdata: got %h want %h", RspData, CAP_EN ? 32'h5 : 32'h0); end
   endtask

   task automatic test_abort();
      logic [5:0] walk;
      logic       rv_any;
      tdo_loop = 1'b0; tdo_val = 1'b1;
      CmdOp = 2'b11; CmdLen = 6'd16; CmdData = 32'h0000_0008; CmdValid = 1'b1;
      cyc();
      CmdValid = 1'b0;
      rv_any = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rv_any = rv_any | (RspValid === 1'b1);
         cyc();
      end
      checks++; if (TDI !== 1'b1) begin errors++; $display("FAIL abort_shift3_tdi: got %b want 1", TDI); end
      checks++; if (TMS !== 1'b0) begin errors++; $display("FAIL abort_shift3_tms: got %b want 0", TMS); end
      Rst = 1'b1;
      cyc();
      checks++; if (TMS !== 1'b1) begin errors++; $display("FAIL abort_rst_tms: got %b want 1", TMS); end
      checks++; if (TDI !== 1'b0) begin errors++; $display("FAIL abort_rst_tdi: got %b want 0", TDI); end
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_rst_busy: got %b want 1", Busy); end
      checks++; if (RspData !== 32'd0) begin errors++; $display("FAIL abort_rst_rspdata: got %h want 0", RspData); end
      Rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rv_any = rv_any | (RspValid === 1'b1);
         cyc();
         walk[i] = TMS;
      end
      checks++; if (walk !== 6'b011111) begin errors++; $display("FAIL abort_walk_tms: got %b want 011111", walk); end
      cyc();
      rv_any = rv_any | (RspValid === 1'b1);
      checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL abort_ready_c7: got %b want 1", CmdReady); end
      cyc();
      rv_any = rv_any | (RspValid === 1'b1);
      checks++; if (rv_any !== 1'b0) begin errors++; $display("FAIL abort_rspvalid: got %b want 0", rv_any); end
   endtask

   initial begin
      test_reset();
      test_reset_op();
      test_idle();
      test_shift_ir();
      test_shift_len1();
      test_shift_dr_clamp();
      test_back_to_back();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tap_sequencer.md
TAP_SEQUENCER -- requirements
Module: tap_sequencer

Interface
REQ-001 SHALL have port TCLK, input, 1 bit: sole clock; TMS/TDI/handshake registers update on falling edge, TDO sampled on rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high, sampled on falling edge of TCLK.
REQ-003 SHALL have port CmdValid, input, 1 bit: command request.
REQ-004 SHALL have port CmdReady, output, 1 bit: sequencer idle and accepting a command.
REQ-005 SHALL have port CmdOp, input, 2 bits: 00 RESET, 01 IDLE, 10 SHIFT_IR, 11 SHIFT_DR.
REQ-006 SHALL have port CmdLen, input, 6 bits: bit count (shift ops) or idle cycle count.
REQ-007 SHALL have port CmdData, input, 32 bits: TDI payload, LSB shifted first.
REQ-008 SHALL have port TDO, input, 1 bit: serial data returned from the TAP chain.
REQ-009 SHALL have port TMS, output, 1 bit: drives the TAP controller TMS.
REQ-010 SHALL have port TDI, output, 1 bit: serial data to the TAP chain.
REQ-011 SHALL have port RspValid, output, 1 bit: one-cycle pulse, shift result available.
REQ-012 SHALL have port RspData, output, 32 bits: captured TDO bits, first bit in bit 0, right-justified.
REQ-013 SHALL have port Busy, output, 1 bit: high whenever CmdReady is low.

Function
REQ-014 SHALL track the target TAP state internally; states: WALK_RST, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE.
REQ-015 SHALL accept a command on a falling edge with CmdValid=1 and CmdReady=1; CmdOp, CmdLen and CmdData latched then; CmdReady drops on the next falling edge.
REQ-016 SHALL clamp effective length: CmdLen=0 -> 1, CmdLen>32 -> 32.
REQ-017 RESET op: TMS=1 for 5 cycles, then TMS=0 for 1 cycle, back to IDLE.
REQ-018 IDLE op: TMS=0 for effective-length cycles.
REQ-019 SHIFT_DR op TMS sequence: 1,0,0, then N shift cycles (TMS=0 for the first N-1, TMS=1 on the last), then 1,0; total N+5 cycles.
REQ-020 SHIFT_IR op TMS sequence: 1,1,0,0, then N shift cycles as in REQ-019, then 1,0; total N+6 cycles.
REQ-021 SHALL present CmdData[i] on TDI during shift cycle i; outside shift cycles TDI=0.
REQ-022 SHALL sample TDO on the rising edge of each shift cycle into bit i of the capture register; RspData bits N..31 = 0.
REQ-023 SHALL pulse RspValid for one cycle coincident with the first IDLE cycle after a shift op; RspData held until the next shift op completes; no RspValid for RESET/IDLE ops.
REQ-024 SHALL hold TMS=0 while IDLE with no command pending.
REQ-025 SHALL assert CmdReady on the same falling edge that RspValid asserts, so back-to-back commands are allowed.

Reset
REQ-026 On Rst: TMS=1, TDI=0, CmdReady=0, Busy=1, RspValid=0, RspData=0, state WALK_RST.
REQ-027 After Rst deasserts: 5 cycles TMS=1, 1 cycle TMS=0, then IDLE with CmdReady=1.
REQ-028 Rst mid-command SHALL abort with no RspValid and restart REQ-027.

Configuration
REQ-029 Macro TAP_SEQ_TDO_CAPTURE_EN: defined -> TDO capture per REQ-022/023; undefined -> no capture register, RspData tied 0, RspValid still pulses per REQ-023.

Structure
REQ-030 Package tap_seq_pkg SHALL hold the opcode enum, the state enum, MAX_LEN=32 and RESET_WALK=5.
REQ-031 Sub-module tap_seq_shifter SHALL hold the 32-bit TDI shift register, the TDO capture register and the bit counter.

Verification
REQ-032 Reset release -> TMS 1,1,1,1,1,0, then CmdReady=1 on cycle 7.
REQ-033 SHIFT_IR, len 4, data 0x5, TDO tied 1 -> TMS 1,1,0,0,0,0,0,1,1,0; TDI 1,0,1,0 in shift cycles; RspData=0x0000000F, RspValid single pulse.
REQ-034 SHIFT_DR, len 40, data 0xA5A5A5A5, TDO looped to TDI -> 32 shift cycles (clamped), RspData=0xA5A5A5A5.
REQ-035 IDLE, len 0 -> exactly 1 TMS=0 cycle; CmdReady low for that cycle only.
REQ-036 Rst asserted in shift cycle 3 of a 16-bit DR shift -> RspValid never asserts; reset walk per REQ-027.
REQ-037 Build without TAP_SEQ_TDO_CAPTURE_EN, run REQ-033 -> RspData=0, RspValid single pulse.
